// File: rtl/outmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// outmem_port_arbiter_if
// Purpose : bundles the accumulator, output-memory and PS register-bus signals
//           that meet at the output-memory port arbiter.
// Modports:
//   slave  - the arbiter: takes acc_* / ps_* requests and mem_* read returns;
//            drives the mem_* request port, the responses and the statistics.
//   master - the surrounding logic (accumulator, memory, PS bus, or a bench).
// Signals : acc_{wadd,wren,idat,radd,rden,odat,ovld,hold},
//           mem_{wadd,wren,idat,radd,rden,odat,ovld},
//           ps_{addr,wren,wdat,rden,rdat,rvld,wack,err},
//           stat_ps_wait_max, stat_acc_hold_cnt.
// ---------------------------------------------------------------------------
interface outmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // accumulator side
    logic [ADDR_WIDTH-1:0] acc_wadd;
    logic                  acc_wren;
    logic [DATA_WIDTH-1:0] acc_idat;
    logic [ADDR_WIDTH-1:0] acc_radd;
    logic                  acc_rden;
    logic [DATA_WIDTH-1:0] acc_odat;
    logic                  acc_ovld;
    logic                  acc_hold;
    // physical 1W1R output memory side
    logic [ADDR_WIDTH-1:0] mem_wadd;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_idat;
    logic [ADDR_WIDTH-1:0] mem_radd;
    logic                  mem_rden;
    logic [DATA_WIDTH-1:0] mem_odat;
    logic                  mem_ovld;
    // PS register bus side
    logic [ADDR_WIDTH-1:0] ps_addr;
    logic                  ps_wren;
    logic [DATA_WIDTH-1:0] ps_wdat;
    logic                  ps_rden;
    logic [DATA_WIDTH-1:0] ps_rdat;
    logic                  ps_rvld;
    logic                  ps_wack;
    logic                  ps_err;
    // statistics
    logic [15:0]           stat_ps_wait_max;
    logic [31:0]           stat_acc_hold_cnt;

    modport slave (
        input  acc_wadd, acc_wren, acc_idat, acc_radd, acc_rden,
        output acc_odat, acc_ovld, acc_hold,
        output mem_wadd, mem_wren, mem_idat, mem_radd, mem_rden,
        input  mem_odat, mem_ovld,
        input  ps_addr, ps_wren, ps_wdat, ps_rden,
        output ps_rdat, ps_rvld, ps_wack, ps_err,
        output stat_ps_wait_max, stat_acc_hold_cnt
    );

    modport master (
        output acc_wadd, acc_wren, acc_idat, acc_radd, acc_rden,
        input  acc_odat, acc_ovld, acc_hold,
        input  mem_wadd, mem_wren, mem_idat, mem_radd, mem_rden,
        output mem_odat, mem_ovld,
        output ps_addr, ps_wren, ps_wdat, ps_rden,
        input  ps_rdat, ps_rvld, ps_wack, ps_err,
        input  stat_ps_wait_max, stat_acc_hold_cnt
    );
endinterface

// File: rtl/outmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// outmem_port_arbiter
// Purpose : shares the 1W1R output (psum) memory between the accumulator and
//           the PS register bus. The accumulator always wins a port; PS
//           accesses wait in one write slot and one read slot and fill idle
//           cycles. Read returns are routed to their owner by a tag pipe whose
//           depth matches the memory read latency.
// Ports   :
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - outmem_port_arbiter_if.slave (acc_*, mem_*, ps_*, stat_*)
// Option  : define OUTMEM_ARB_STAT_EN to build the wait/hold statistics
//           counters; otherwise stat_ps_wait_max / stat_acc_hold_cnt read 0.
// ---------------------------------------------------------------------------
module outmem_port_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DELAY  = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hE000_0000,
    parameter int                    WIN_WIDTH  = 16,
    parameter int                    WAIT_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    outmem_port_arbiter_if.slave  bus
);

    typedef enum logic { OWN_ACC = 1'b0, OWN_PS = 1'b1 } owner_e;
    typedef struct packed {
        logic   vld;
        owner_e own;
    } tag_t;

    localparam logic [15:0] WAIT_LIM16 = 16'(WAIT_LIMIT);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // pending PS slots
    logic                  r_wr_full, r_rd_full;
    logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [15:0]           r_wr_wait, r_rd_wait;
    logic                  r_err, r_hold;
    logic [DATA_WIDTH-1:0] r_ps_rdat;
    logic                  r_ps_rvld;
    tag_t                  r_tag [MEM_DELAY];

    logic [ADDR_WIDTH-1:0] w_ps_off;
    logic                  w_ps_in_win;
    logic                  w_acc_wr, w_acc_rd, w_ps_wr_go, w_ps_rd_go;
    logic                  w_wr_accept, w_wr_drop, w_rd_accept, w_rd_drop;
    logic                  w_wr_full_nxt, w_rd_full_nxt, w_hold_set;
    logic [15:0]           w_wr_wait_nxt, w_rd_wait_nxt;
    tag_t                  w_tag_in, w_head;
    logic                  w_to_acc, w_to_ps;

    // window decode: offset is the memory word address
    assign w_ps_off    = bus.ps_addr - BASE_ADDR;
    assign w_ps_in_win = (bus.ps_addr >= BASE_ADDR) && ((w_ps_off >> WIN_WIDTH) == '0);

    // grant: accumulator first, PS slot only on an idle port
    assign w_acc_wr   = ~rst & bus.acc_wren;
    assign w_acc_rd   = ~rst & bus.acc_rden;
    assign w_ps_wr_go = ~rst & ~bus.acc_wren & r_wr_full;
    // a PS read to the address the PS write is committing now waits one
    // cycle so it returns the new data instead of the old word
    assign w_ps_rd_go = ~rst & ~bus.acc_rden & r_rd_full
                        & ~(w_ps_wr_go && (r_wr_addr == r_rd_addr));

    // slot occupancy is judged on the registered flag: a pulse arriving in
    // the same cycle its slot drains is still dropped
    assign w_wr_accept = bus.ps_wren & w_ps_in_win & ~r_wr_full;
    assign w_wr_drop   = bus.ps_wren & w_ps_in_win &  r_wr_full;
    assign w_rd_accept = bus.ps_rden & w_ps_in_win & ~r_rd_full;
    assign w_rd_drop   = bus.ps_rden & w_ps_in_win &  r_rd_full;

    assign w_wr_full_nxt = w_wr_accept | (r_wr_full & ~w_ps_wr_go);
    assign w_rd_full_nxt = w_rd_accept | (r_rd_full & ~w_ps_rd_go);
    assign w_wr_wait_nxt = (r_wr_full & ~w_ps_wr_go) ? sat_inc16(r_wr_wait) : 16'd0;
    assign w_rd_wait_nxt = (r_rd_full & ~w_ps_rd_go) ? sat_inc16(r_rd_wait) : 16'd0;
    assign w_hold_set    = (w_wr_wait_nxt >= WAIT_LIM16) | (w_rd_wait_nxt >= WAIT_LIM16);

    // memory request port, combinational for zero added acc latency
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        bus.mem_wren = 1'b0;
        bus.mem_wadd = '0;
        bus.mem_idat = '0;
        bus.mem_rden = 1'b0;
        bus.mem_radd = '0;
        if (w_acc_wr) begin
            bus.mem_wren = 1'b1;
            bus.mem_wadd = bus.acc_wadd;
            bus.mem_idat = bus.acc_idat;
        end else if (w_ps_wr_go) begin
            bus.mem_wren = 1'b1;
            bus.mem_wadd = r_wr_addr;
            bus.mem_idat = r_wr_data;
        end
        if (w_acc_rd) begin
            bus.mem_rden = 1'b1;
            bus.mem_radd = bus.acc_radd;
        end else if (w_ps_rd_go) begin
            bus.mem_rden = 1'b1;
            bus.mem_radd = r_rd_addr;
        end
    end

    // tag pipe: one entry per issued read, head lines up with mem_ovld
    assign w_tag_in = '{vld: w_acc_rd | w_ps_rd_go, own: (w_acc_rd ? OWN_ACC : OWN_PS)};
    assign w_head   = r_tag[MEM_DELAY-1];

    always_ff @(posedge clk) begin
        // NOTE: the tag pipe is cleared explicitly; stale valid bits would misroute returns that land after reset.
        if (rst) begin
            for (int i = 0; i < MEM_DELAY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < MEM_DELAY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign w_to_acc = ~rst & bus.mem_ovld & w_head.vld & (w_head.own == OWN_ACC);
    assign w_to_ps  = ~rst & bus.mem_ovld & w_head.vld & (w_head.own == OWN_PS);

    always_ff @(posedge clk) begin
        // NOTE: state uses <= so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_wr_full <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_wait <= '0;
            r_rd_full <= 1'b0;
            r_rd_addr <= '0;
            r_rd_wait <= '0;
            r_err     <= 1'b0;
            r_hold    <= 1'b0;
            r_ps_rdat <= '0;
            r_ps_rvld <= 1'b0;
        end else begin
            r_wr_full <= w_wr_full_nxt;
            r_rd_full <= w_rd_full_nxt;
            r_wr_wait <= w_wr_wait_nxt;
            r_rd_wait <= w_rd_wait_nxt;
            if (w_wr_accept) begin
                r_wr_addr <= w_ps_off;
                r_wr_data <= bus.ps_wdat;
            end
            if (w_rd_accept) r_rd_addr <= w_ps_off;
            if (w_wr_drop || w_rd_drop) r_err <= 1'b1;
            // hold releases as soon as both slots are known to be empty next cycle
            if (w_hold_set) r_hold <= 1'b1;
            else if (!w_wr_full_nxt && !w_rd_full_nxt) r_hold <= 1'b0;
            r_ps_rvld <= w_to_ps;
            if (w_to_ps) r_ps_rdat <= bus.mem_odat;
        end
    end

    assign bus.acc_odat = w_to_acc ? bus.mem_odat : '0;
    assign bus.acc_ovld = w_to_acc;
    assign bus.acc_hold = r_hold;
    assign bus.ps_rdat  = r_ps_rdat;
    assign bus.ps_rvld  = r_ps_rvld;
    assign bus.ps_wack  = w_ps_wr_go;
    assign bus.ps_err   = r_err;

`ifdef OUTMEM_ARB_STAT_EN
    logic [15:0] r_stat_wait_max;
    logic [31:0] r_stat_hold_cnt;
    logic [15:0] w_grant_wait;

    // largest wait among the slots granted this cycle
    always_comb begin
        w_grant_wait = 16'd0;
        if (w_ps_wr_go) w_grant_wait = r_wr_wait;
        if (w_ps_rd_go && (r_rd_wait > w_grant_wait)) w_grant_wait = r_rd_wait;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wait_max <= '0;
            r_stat_hold_cnt <= '0;
        end else begin
            if (w_grant_wait > r_stat_wait_max) r_stat_wait_max <= w_grant_wait;
            if (r_hold && (r_stat_hold_cnt != 32'hFFFF_FFFF))
                r_stat_hold_cnt <= r_stat_hold_cnt + 32'd1;
        end
    end

    assign bus.stat_ps_wait_max  = r_stat_wait_max;
    assign bus.stat_acc_hold_cnt = r_stat_hold_cnt;
`else
    assign bus.stat_ps_wait_max  = '0;
    assign bus.stat_acc_hold_cnt = '0;
`endif

endmodule

// File: tb/tb_outmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_outmem_port_arbiter
// Purpose : directed bench for outmem_port_arbiter. u_dut1 runs with a
//           1-cycle memory, u_dut3 with a 3-cycle memory; both WAIT_LIMIT=4.
//           Each has a small behavioural 1W1R memory model.
// ---------------------------------------------------------------------------
module tb_outmem_port_arbiter;

    logic clk = 1'b0;
    logic rst1, rst3;
    always #5 clk = ~clk;

    outmem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
    outmem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

    outmem_port_arbiter #(.MEM_DELAY(1), .WAIT_LIMIT(4)) u_dut1 (.clk(clk), .rst(rst1), .bus(b1));
    outmem_port_arbiter #(.MEM_DELAY(3), .WAIT_LIMIT(4)) u_dut3 (.clk(clk), .rst(rst3), .bus(b3));

    // memory models (not reset: in-flight data keeps coming across a DUT reset)
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] md1;
    logic        mv1;
    logic [31:0] md3 [3];
    logic        mv3 [3];

    always @(posedge clk) begin
        if (b1.mem_wren) mem1[b1.mem_wadd[7:0]] <= b1.mem_idat;
        mv1 <= b1.mem_rden;
        md1 <= mem1[b1.mem_radd[7:0]];
        if (b3.mem_wren) mem3[b3.mem_wadd[7:0]] <= b3.mem_idat;
        mv3[0] <= b3.mem_rden;
        md3[0] <= mem3[b3.mem_radd[7:0]];
        for (int i = 1; i < 3; i++) begin
            mv3[i] <= mv3[i-1];
            md3[i] <= md3[i-1];
        end
    end
    assign b1.mem_ovld = mv1;
    assign b1.mem_odat = md1;
    assign b3.mem_ovld = mv3[2];
    assign b3.mem_odat = md3[2];

    // response event counters
    int   n_acc1, n_rv1, n_acc3, n_rv3;
    logic mon_clr;
    always @(negedge clk) begin
        if (mon_clr) begin
            n_acc1 <= 0; n_rv1 <= 0; n_acc3 <= 0; n_rv3 <= 0;
        end else begin
            if (b1.acc_ovld === 1'b1) n_acc1 <= n_acc1 + 1;
            if (b1.ps_rvld  === 1'b1) n_rv1  <= n_rv1 + 1;
            if (b3.acc_ovld === 1'b1) n_acc3 <= n_acc3 + 1;
            if (b3.ps_rvld  === 1'b1) n_rv3  <= n_rv3 + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        b1.acc_wadd = '0; b1.acc_wren = 1'b0; b1.acc_idat = '0;
        b1.acc_radd = '0; b1.acc_rden = 1'b0;
        b1.ps_addr  = '0; b1.ps_wren  = 1'b0; b1.ps_wdat  = '0; b1.ps_rden = 1'b0;
        b3.acc_wadd = '0; b3.acc_wren = 1'b0; b3.acc_idat = '0;
        b3.acc_radd = '0; b3.acc_rden = 1'b0;
        b3.ps_addr  = '0; b3.ps_wren  = 1'b0; b3.ps_wdat  = '0; b3.ps_rden = 1'b0;
    endtask

    task automatic clear_counts();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst1 = 1'b1; rst3 = 1'b1; mon_clr = 1'b1;
        repeat (3) step();
        sample();
        check("rst_mem_req", 32'({b1.mem_wren, b1.mem_rden, b1.acc_ovld, b1.acc_hold}), 32'd0);
        check("rst_ps_out",  32'({b1.ps_rvld, b1.ps_wack, b1.ps_err}), 32'd0);
        check("rst_ps_rdat", b1.ps_rdat, 32'd0);
        check("rst_stats",   32'(b1.stat_ps_wait_max) | b1.stat_acc_hold_cnt, 32'd0);
        step();
        rst1 = 1'b0; rst3 = 1'b0; mon_clr = 1'b0;

        // accumulator write forwarding, also preloads words 0..7
        for (int i = 0; i < 8; i++) begin
            b1.acc_wren = 1'b1; b1.acc_wadd = 32'(i); b1.acc_idat = 32'h1111_0000 + 32'(i);
            sample();
            if (i == 5) begin
                check("acc_wr_en",   32'({b1.mem_wren, b1.ps_wack}), 32'd2);
                check("acc_wr_addr", b1.mem_wadd, 32'd5);
                check("acc_wr_data", b1.mem_idat, 32'h1111_0005);
            end
            step();
        end
        b1.acc_wren = 1'b0;

        // PS write then PS read of the same word, idle accumulator
        b1.ps_addr = 32'hE000_0004; b1.ps_wdat = 32'hA5A5_A5A5; b1.ps_wren = 1'b1;
        sample(); check("t1_no_early_wr", 32'(b1.mem_wren), 32'd0); step();
        b1.ps_wren = 1'b0;
        sample();
        check("t1_wren_wack", 32'({b1.mem_wren, b1.ps_wack}), 32'd3);
        check("t1_wadd", b1.mem_wadd, 32'd4);
        check("t1_idat", b1.mem_idat, 32'hA5A5_A5A5);
        step();
        b1.ps_rden = 1'b1;
        sample(); check("t1_wack_pulse", 32'(b1.ps_wack), 32'd0); step();
        b1.ps_rden = 1'b0;
        sample();
        check("t1_rden", 32'(b1.mem_rden), 32'd1);
        check("t1_radd", b1.mem_radd, 32'd4);
        step();
        sample(); check("t1_ovld_cycle", 32'({b1.acc_ovld, b1.ps_rvld}), 32'd0); step();
        sample();
        check("t1_rvld", 32'(b1.ps_rvld), 32'd1);
        check("t1_rdat", b1.ps_rdat, 32'hA5A5_A5A5);
        step();
        sample(); check("t1_rvld_pulse", 32'(b1.ps_rvld), 32'd0); step();

        // write and read to one word pulsed together: write commits first
        b1.ps_addr = 32'hE000_0008; b1.ps_wdat = 32'h5A5A_0008;
        b1.ps_wren = 1'b1; b1.ps_rden = 1'b1;
        step();
        b1.ps_wren = 1'b0; b1.ps_rden = 1'b0;
        sample();
        check("t1b_wr_first", 32'({b1.mem_wren, b1.mem_rden}), 32'd2);
        check("t1b_wadd", b1.mem_wadd, 32'd8);
        step();
        sample();
        check("t1b_rd_next", 32'({b1.mem_wren, b1.mem_rden}), 32'd1);
        check("t1b_radd", b1.mem_radd, 32'd8);
        step();
        step();
        sample(); check("t1b_rdat", b1.ps_rdat, 32'h5A5A_0008); step();

        // window decode: below, one past the top, and the last word
        b1.ps_addr = 32'hD000_0000; b1.ps_wren = 1'b1; b1.ps_rden = 1'b1; step();
        b1.ps_wren = 1'b0; b1.ps_rden = 1'b0;
        sample(); check("win_below", 32'({b1.mem_wren, b1.ps_wack, b1.mem_rden}), 32'd0); step();
        b1.ps_addr = 32'hE001_0000; b1.ps_wren = 1'b1; step();
        b1.ps_wren = 1'b0;
        sample(); check("win_above", 32'({b1.mem_wren, b1.ps_wack}), 32'd0); step();
        b1.ps_addr = 32'hE000_FFFF; b1.ps_wdat = 32'h0000_BEEF; b1.ps_wren = 1'b1; step();
        b1.ps_wren = 1'b0;
        sample();
        check("win_top_wren", 32'({b1.mem_wren, b1.ps_wack}), 32'd3);
        check("win_top_addr", b1.mem_wadd, 32'h0000_FFFF);
        check("win_no_err", 32'(b1.ps_err), 32'd0);
        step();

        // 10 back-to-back acc reads, one PS read pulse at cycle 2
        clear_counts();
        for (int k = 0; k < 11; k++) begin
            b1.acc_rden = (k < 10); b1.acc_radd = 32'(k % 8);
            b1.ps_rden = (k == 2); b1.ps_addr = 32'hE000_0006;
            sample();
            if (k == 1) begin
                check("t2_acc_ovld", 32'(b1.acc_ovld), 32'd1);
                check("t2_acc_odat", b1.acc_odat, 32'h1111_0000);
            end
            if (k == 6) check("t2_hold_low", 32'(b1.acc_hold), 32'd0);
            if (k == 7) check("t2_hold_high", 32'(b1.acc_hold), 32'd1);
            if (k == 9) check("t2_acc_radd", b1.mem_radd, 32'd1);
            if (k == 10) begin
                check("t2_ps_issue", 32'(b1.mem_rden), 32'd1);
                check("t2_ps_radd", b1.mem_radd, 32'd6);
            end
            step();
        end
        b1.acc_rden = 1'b0; b1.ps_rden = 1'b0;
        sample(); check("t2_hold_drop", 32'(b1.acc_hold), 32'd0); step();
        step();
        sample();
        check("t2_n_acc_ovld", 32'(n_acc1), 32'd10);
        check("t2_n_ps_rvld", 32'(n_rv1), 32'd1);
        check("t2_ps_rdat", b1.ps_rdat, 32'h1111_0006);
        step();

        // acc_wren held: PS write starves, hold rises, then write drains
        b1.acc_wren = 1'b1; b1.acc_wadd = 32'h20; b1.acc_idat = 32'h0000_2020;
        b1.ps_addr = 32'hE000_0010; b1.ps_wdat = 32'hCAFE_0010; b1.ps_wren = 1'b1;
        step();
        b1.ps_wren = 1'b0;
        for (int c = 1; c < 6; c++) begin
            sample();
            if (c == 1) begin
                check("t3_acc_wins", b1.mem_wadd, 32'h20);
                check("t3_no_wack", 32'(b1.ps_wack), 32'd0);
            end
            if (c == 4) check("t3_hold_low", 32'(b1.acc_hold), 32'd0);
            if (c == 5) check("t3_hold_high", 32'(b1.acc_hold), 32'd1);
            step();
        end
        b1.acc_wren = 1'b0;
        sample();
        check("t3_ps_wr", 32'({b1.mem_wren, b1.ps_wack, b1.acc_hold}), 32'd7);
        check("t3_ps_wadd", b1.mem_wadd, 32'h10);
        check("t3_ps_idat", b1.mem_idat, 32'hCAFE_0010);
        step();
        sample();
        check("t3_hold_fall", 32'(b1.acc_hold), 32'd0);
`ifdef OUTMEM_ARB_STAT_EN
        check("stat_wait_max", 32'(b1.stat_ps_wait_max), 32'd7);
        check("stat_hold_cnt", b1.stat_acc_hold_cnt, 32'd6);
`else
        check("stat_wait_max", 32'(b1.stat_ps_wait_max), 32'd0);
        check("stat_hold_cnt", b1.stat_acc_hold_cnt, 32'd0);
`endif
        step();

        // two PS reads back-to-back while acc reads: second dropped
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            b1.acc_rden = (k < 6); b1.acc_radd = 32'd0;
            b1.ps_rden = (k < 2);
            b1.ps_addr = (k == 0) ? 32'hE000_0002 : 32'hE000_0003;
            sample();
            if (k == 0) check("t4_err_clear", 32'(b1.ps_err), 32'd0);
            if (k == 2) check("t4_err_set", 32'(b1.ps_err), 32'd1);
            if (k == 6) check("t4_ps_radd", b1.mem_radd, 32'd2);
            if (k == 8) check("t4_ps_rdat", b1.ps_rdat, 32'h1111_0002);
            step();
        end
        b1.ps_rden = 1'b0;
        sample();
        check("t4_n_ps_rvld", 32'(n_rv1), 32'd1);
        check("t4_n_acc_ovld", 32'(n_acc1), 32'd6);
        check("t4_err_sticky", 32'(b1.ps_err), 32'd1);
        step();
        rst1 = 1'b1; step(); rst1 = 1'b0;
        sample(); check("t4_err_rst", 32'({b1.ps_err, b1.acc_hold}), 32'd0); step();

        // MEM_DELAY=3: clean interleave, then the same with a reset mid-flight
        for (int pass = 0; pass < 2; pass++) begin
            clear_counts();
            for (int k = 0; k < 9; k++) begin
                b3.acc_rden = (k == 0 || k == 2); b3.acc_radd = 32'd1;
                b3.ps_rden = (k == 0); b3.ps_addr = 32'hE000_0001;
                rst3 = (pass == 1 && k == 3);
                sample();
                if (pass == 0) begin
                    if (k == 1) check("t6_ps_issue", 32'({b3.mem_rden, b3.mem_radd[7:0]}), 32'h101);
                    if (k == 2) check("t6_no_early", 32'(b3.acc_ovld), 32'd0);
                    if (k == 3) check("t6_acc_lat3", 32'(b3.acc_ovld), 32'd1);
                    if (k == 4) check("t6_ps_gap", 32'({b3.acc_ovld, b3.ps_rvld}), 32'd0);
                    if (k == 5) check("t6_both", 32'({b3.acc_ovld, b3.ps_rvld}), 32'd3);
                end
                step();
            end
            rst3 = 1'b0;
            sample();
            if (pass == 0) begin
                check("t6_n_acc", 32'(n_acc3), 32'd2);
                check("t6_n_ps", 32'(n_rv3), 32'd1);
            end else begin
                check("t6_rst_n_acc", 32'(n_acc3), 32'd0);
                check("t6_rst_n_ps", 32'(n_rv3), 32'd0);
                check("t6_rst_stats", 32'(b3.stat_ps_wait_max) | b3.stat_acc_hold_cnt, 32'd0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/outmem_port_arbiter.md
Name: outmem_port_arbiter

Overview:
Shares the output (psum) memory port between the psum accumulation controller and the PS register bus, so software can read back or preload outputs while, or between, layer runs.
- Sits between the accumulator's memctrl0_* port and the physical 1W1R output memory.
- The accumulator always has priority. PS accesses fill idle slots.
- Read returns are routed back to the owning requester by a latency-matched tag pipe.

Parameters:
ADDR_WIDTH, 32, memory/PS address width
DATA_WIDTH, 32, memory data width
MEM_DELAY, 1, memory read latency in cycles (1..8)
BASE_ADDR, 32'hE0000000, PS window base; mem address = ps_addr - BASE_ADDR
WIN_WIDTH, 16, PS window size = 2^WIN_WIDTH words
WAIT_LIMIT, 64, PS pending cycles before acc_hold asserts

Ports:
clk in 1 clock
rst in 1 synchronous active-high reset
acc_wadd in ADDR_WIDTH accumulator write address
acc_wren in 1 accumulator write enable
acc_idat in DATA_WIDTH accumulator write data
acc_radd in ADDR_WIDTH accumulator read address
acc_rden in 1 accumulator read enable
acc_odat out DATA_WIDTH read data to accumulator
acc_ovld out 1 read valid to accumulator
acc_hold out 1 request: accumulator pauses new accesses
mem_wadd out ADDR_WIDTH memory write address
mem_wren out 1 memory write enable
mem_idat out DATA_WIDTH memory write data
mem_radd out ADDR_WIDTH memory read address
mem_rden out 1 memory read enable
mem_odat in DATA_WIDTH memory read data
mem_ovld in 1 memory read valid
ps_addr in ADDR_WIDTH PS address
ps_wren in 1 PS write pulse
ps_wdat in DATA_WIDTH PS write data
ps_rden in 1 PS read pulse
ps_rdat out DATA_WIDTH PS read data
ps_rvld out 1 PS read valid pulse
ps_wack out 1 PS write committed pulse
ps_err out 1 sticky: PS request dropped
stat_ps_wait_max out 16 max PS wait cycles (optional feature)
stat_acc_hold_cnt out 32 cycles with acc_hold high (optional feature)

Behaviour:
- Reset values: all outputs 0; both pending slots empty; tag pipe cleared.
- PS decode: request accepted only when BASE_ADDR <= ps_addr < BASE_ADDR + 2^WIN_WIDTH. Out-of-window requests are ignored: no ps_err, no response.
- Pending slots: one write slot and one read slot, independent.
  - An accepted pulse latches address (and data, for writes) into its slot.
  - A pulse to an already-occupied slot is dropped and sets ps_err. ps_err is cleared only by rst.
- Write port, each cycle:
  - acc_wren=1: forward the acc write.
  - Else, write slot full: issue the PS write, free the slot, pulse ps_wack in the same cycle.
- Read port, each cycle:
  - acc_rden=1: forward the acc read.
  - Else, read slot full: issue the PS read and free the slot.
- Mem outputs are combinational from the inputs and slot registers (zero added latency on the accumulator path).
- Tag pipe: MEM_DELAY-deep shift register of {valid, owner}, pushed on every mem_rden.
  - On mem_ovld, the head tag selects the destination.
  - acc owner: acc_odat=mem_odat, acc_ovld=1, same cycle.
  - ps owner: ps_rdat registered, ps_rvld pulses 1 cycle later.
  - mem_ovld with an empty tag is ignored.
- Accumulator write and PS write in the same cycle: the accumulator wins; the PS write stays pending.
- A PS write and a PS read to the same address pending together: the write issues first only if both ports are idle; ordering otherwise is not guaranteed. Software must poll ps_wack.
- Wait counter per slot counts cycles pending.
  - When either counter reaches WAIT_LIMIT, acc_hold=1 (registered).
  - acc_hold drops the cycle after both slots are empty.
  - acc_hold is advisory: the grant rule is unchanged.
- Reset mid-operation: slots and tag pipe flush; in-flight read data arriving after rst deassert is discarded.

Optional Feature:
OUTMEM_ARB_STAT_EN:
- Defined:
  - stat_ps_wait_max tracks the largest wait-counter value at slot grant, saturating at 16'hFFFF.
  - stat_acc_hold_cnt counts acc_hold cycles, saturating at 32'hFFFFFFFF.
  - Both reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- MEM_DELAY=1, idle accumulator; PS write 0xE0000004 data 0xA5A5A5A5, then PS read same addr -> mem_wadd=4 write, ps_wack pulses; ps_rvld one cycle after mem_ovld with ps_rdat=0xA5A5A5A5.
- acc_rden continuous for 10 cycles plus one PS read pulse at cycle 2 -> PS read issued at cycle 10; acc_ovld for all 10 acc reads; exactly one ps_rvld.
- WAIT_LIMIT=4, acc_wren held high, PS write pending -> acc_hold rises after 4 pending cycles; acc_wren dropped -> PS write issues, acc_hold falls next cycle.
- Two PS reads back-to-back while acc_rden busy -> second dropped, ps_err=1 until rst; only one ps_rvld.
- ps_addr=0xD0000000 write pulse -> no mem_wren, no ps_wack, ps_err stays 0.
- MEM_DELAY=3, interleaved acc/PS reads, rst asserted mid-flight -> no acc_ovld/ps_rvld after reset; with OUTMEM_ARB_STAT_EN, stats read 0.
